gpio_pattern_pacer: RTL and testbench
=====================================

// Module: gpio_pattern_pacer
// PURPOSE
//  User-project-side source for the mprj_io[7:0] pattern check (01..0A, FF, 00).
//  Accepts bytes from the vsdmemsoc core over a valid/ready handshake and buffers them in a small FIFO.
//  Presents each byte on io_out[7:0] for at least HOLD_CYCLES clocks, so a slow external monitor sees
//  every value. Sits between the core output register and the user_project_wrapper io_out/io_oeb pins.
// PARAMETERS
//  WIDTH        8   data / pad width driven on io_out
//  DEPTH        4   FIFO entries; power of 2, >= 2
//  HOLD_CYCLES  16  minimum clocks each value stays on io_out; >= 1
// PORTS
//  wb_clk_i   in   1             single clock; all logic on rising edge
//  wb_rst_i   in   1             synchronous reset, active-high
//  en         in   1             1 = drive pads and run sequencer; 0 = freeze, pads tri-stated
//  in_valid   in   1             core has a byte to send
//  in_data    in   WIDTH         byte to present on pads
//  in_ready   out  1             FIFO can accept; transfer when in_valid & in_ready
//  io_out     out  WIDTH         pad output value
//  io_oeb     out  WIDTH         pad output-enable, active-low, all bits identical
//  busy       out  1             1 while in HOLD or FIFO non-empty
//  level      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (wb_rst_i=1 at an edge): io_out=0, io_oeb='1, in_ready=0 for that cycle, busy=0, level=0.
//   FIFO pointers cleared; state=IDLE; hold counter=0. Applies mid-HOLD too: queued data is discarded.
//  in_ready = en & ~full & ~wb_rst_i (combinational). No push when full; push into a full FIFO never happens.
//  io_oeb = {WIDTH{~en}}, registered: updates at the edge after en changes.
//  FIFO: circular buffer with pointers of $clog2(DEPTH)+1 bits (extra wrap bit).
//   full  = ptrs equal except MSB; empty = ptrs equal; pointers wrap modulo 2*DEPTH.
//   No bypass path: a byte pushed at edge E is poppable at earliest at edge E+1.
//   Simultaneous push and pop in one cycle is legal; level stays unchanged.
//  Sequencer states:
//   IDLE: if en & ~empty: pop head; at that same edge io_out<=head, cnt<=HOLD_CYCLES-1, go HOLD.
//   HOLD: if ~en: freeze (cnt, io_out held). Else if cnt!=0: cnt<=cnt-1.
//    Else (cnt==0) & ~empty: pop; load next byte; cnt<=HOLD_CYCLES-1; stay HOLD (no gap cycle).
//    Else (cnt==0) & empty: go IDLE; io_out keeps last value.
//   Each value therefore occupies io_out for exactly HOLD_CYCLES clocks when the FIFO is never starved.
//  Latency: handshake sampled at edge E into an empty FIFO, state IDLE -> io_out updates at edge E+1.
//  Repeated identical bytes are each held HOLD_CYCLES; io_out does not toggle between them.
//  en low mid-HOLD: remaining hold time preserved and resumes on en=1; the FIFO accepts nothing.
//  Counter width: $clog2(HOLD_CYCLES+1) bits, unsigned, never underflows.
//  busy = (state==HOLD) | ~empty.
// TESTING
//  T1 HOLD=4, DEPTH=4, en=1: push 01..0A, FF, 00 back-to-back -> io_out shows each value exactly 4 clocks,
//     in order. in_ready drops while level==4. Final io_out=00, busy=0.
//  T2 Single push 5A into idle FIFO at edge E -> io_out=5A at E+1; busy high for 4 clocks then 0;
//     io_out stays 5A.
//  T3 Fill to DEPTH with in_valid held high -> in_ready=0 and level=4. Next pop and push occur in the
//     same cycle -> level stays 4, no data lost or duplicated.
//  T4 en=0 after 2 clocks of a 4-clock HOLD, for 10 clocks -> io_oeb=FF after 1 edge, io_out frozen.
//     en=1 -> io_oeb=00; the value is held 2 more clocks, then the next byte appears.
//  T5 wb_rst_i pulsed mid-HOLD with 3 bytes queued -> next edge io_out=00, io_oeb=FF, level=0;
//     the queued bytes never appear afterwards.
//  T6 HOLD=1 stream of 8 bytes with in_valid continuous -> io_out changes every clock, sequence intact.

Source files
------------

// File: rtl/gpio_pattern_pacer.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pattern_pacer
// Description : Paces a byte stream onto the user-project GPIO pads. Bytes
//               arrive from the core over a valid/ready handshake into a small
//               circular FIFO. A sequencer pops them one at a time and holds
//               each on io_out for HOLD_CYCLES enabled clocks, so a slow
//               external monitor sees every value, including repeats.
// Ports       : wb_clk_i  - single clock, rising edge
//               wb_rst_i  - synchronous reset, active-high
//               en        - 1: drive pads and run sequencer; 0: freeze, pads off
//               in_valid  - core has a byte to send
//               in_data   - byte to queue
//               in_ready  - FIFO can accept (en & ~full & ~reset)
//               io_out    - pad output value
//               io_oeb    - pad output-enable, active-low, all bits identical
//               busy      - sequencer holding a value or FIFO non-empty
//               level     - FIFO occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pattern_pacer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         io_out,
    output logic [WIDTH-1:0]         io_oeb,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_CW-1:0] c_HOLD_RELOAD = c_CW'(HOLD_CYCLES - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [0:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_io_out;
    logic [WIDTH-1:0] r_io_oeb;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means the writer has lapped the reader.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign in_ready = en & ~w_full & ~wb_rst_i;
    assign w_push   = in_valid & in_ready;

    // Pop when idle, or when the current value has served its full hold.
    // The head is read from storage only, so a byte written this edge is
    // never visible to the sequencer until the following edge.
    assign w_pop = en & ~w_empty & ((r_state == c_IDLE) || (r_cnt == '0));

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_io_out <= '0;
        end else if (w_pop) begin
            // Back-to-back load with no gap cycle between consecutive bytes.
            r_io_out <= w_head;
            r_cnt    <= c_HOLD_RELOAD;
            r_state  <= c_HOLD;
        end else if (en && (r_state == c_HOLD)) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CW'(1);
            end else begin
                // Starved: drop to idle but leave the last value on the pads.
                r_state <= c_IDLE;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_io_oeb <= '1;
        end else begin
            r_io_oeb <= {WIDTH{~en}};
        end
    end

    // Wrap-bit subtraction yields 0..DEPTH directly.
    assign level  = r_wr_ptr - r_rd_ptr;
    assign busy   = (r_state == c_HOLD) | ~w_empty;
    assign io_out = r_io_out;
    assign io_oeb = r_io_oeb;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pattern_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pattern_pacer
// Description : Self-checking bench for gpio_pattern_pacer. Two instances run
//               side by side: HOLD_CYCLES=4 and HOLD_CYCLES=1, both DEPTH=4.
//               A queue-and-elapsed-time model predicts every output each
//               cycle; directed checks pin concrete values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pattern_pacer;

    typedef struct packed {
        logic [3:0][7:0] q;       // queued bytes, q[0] is oldest
        int              n;       // number queued
        logic [7:0]      cur;     // value on the pads
        int              shown;   // enabled clocks the current value has been shown
        bit              active;  // a value is being presented
        bit              oeb;
    } model_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, en0, v0, rdy0, busy0;
    logic [7:0] d0, out0, oeb0;
    logic [2:0] lvl0;
    logic       rst1, en1, v1, rdy1, busy1;
    logic [7:0] d1, out1, oeb1;
    logic [2:0] lvl1;

    gpio_pattern_pacer #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(4)) u_dut0 (
        .wb_clk_i (clk),  .wb_rst_i (rst0), .en (en0),
        .in_valid (v0),   .in_data  (d0),   .in_ready (rdy0),
        .io_out   (out0), .io_oeb   (oeb0), .busy (busy0), .level (lvl0)
    );

    gpio_pattern_pacer #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(1)) u_dut1 (
        .wb_clk_i (clk),  .wb_rst_i (rst1), .en (en1),
        .in_valid (v1),   .in_data  (d1),   .in_ready (rdy1),
        .io_out   (out1), .io_oeb   (oeb1), .busy (busy1), .level (lvl1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the pacer's externally visible rules.
    function automatic model_t mstep(input model_t m, input bit rst, input bit en,
                                     input bit valid, input logic [7:0] d, input int hold);
        model_t r;
        bit     rdy;
        r = m;
        if (rst) begin
            r     = '0;
            r.oeb = 1'b1;
            return r;
        end
        rdy   = en && (m.n < 4);
        r.oeb = ~en;
        if (en) begin
            if (m.active && m.shown < hold) begin
                r.shown = m.shown + 1;
            end else if (m.n != 0) begin
                r.cur    = m.q[0];
                r.q      = m.q >> 8;
                r.n      = m.n - 1;
                r.shown  = 1;
                r.active = 1'b1;
            end else begin
                r.active = 1'b0;
            end
        end
        if (valid && rdy && r.n < 4) begin
            r.q[r.n] = d;
            r.n      = r.n + 1;
        end
        return r;
    endfunction

    model_t m0, m1;

    always @(posedge clk) begin
        m0 <= mstep(m0, rst0, en0, v0, d0, 4);
        m1 <= mstep(m1, rst1, en1, v1, d1, 1);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("out0",  out0,  m0.cur);
            chk("oeb0",  oeb0,  {8{m0.oeb}});
            chk("rdy0",  rdy0,  en0 & ~rst0 & (m0.n < 4));
            chk("busy0", busy0, m0.active | (m0.n != 0));
            chk("lvl0",  lvl0,  m0.n);
            chk("out1",  out1,  m1.cur);
            chk("oeb1",  oeb1,  {8{m1.oeb}});
            chk("rdy1",  rdy1,  en1 & ~rst1 & (m1.n < 4));
            chk("busy1", busy1, m1.active | (m1.n != 0));
            chk("lvl1",  lvl1,  m1.n);
        end
    end

    // Run-length log of instance 0's pad value.
    logic [7:0] run_val [$];
    int         run_len [$];
    logic [7:0] lg_prev;
    int         lg_len;
    bit         lg_on = 1'b0;
    bit         saw_full = 1'b0;

    always @(negedge clk) begin
        if (lg_on) begin
            if (out0 !== lg_prev) begin
                run_val.push_back(lg_prev);
                run_len.push_back(lg_len);
                lg_prev = out0;
                lg_len  = 1;
            end else begin
                lg_len = lg_len + 1;
            end
            if (lvl0 == 3'd4 && rdy0 == 1'b0) saw_full = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    // Present one byte on instance 0 and wait (bounded) for the handshake.
    task automatic push0(input logic [7:0] d);
        int t;
        t  = 0;
        v0 = 1'b1;
        d0 = d;
        while (1) begin
            @(negedge clk);
            #1;
            if (rdy0) begin
                @(posedge clk);
                #2;
                break;
            end
            t++;
            if (t > 200) begin
                chk("push0_timeout", 32'd1, 32'd0);
                break;
            end
        end
        v0 = 1'b0;
    endtask

    logic [7:0] t1_seq [12];

    initial begin
        t1_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
        m0 = '0; m0.oeb = 1'b1;
        m1 = '0; m1.oeb = 1'b1;
        rst0 = 1'b1; en0 = 1'b1; v0 = 1'b0; d0 = 8'h00;
        rst1 = 1'b1; en1 = 1'b1; v1 = 1'b0; d1 = 8'h00;

        @(posedge clk);
        #1 cmp_on = 1'b1;
        step(1);

        // Reset state, sampled while reset is still asserted.
        sample();
        chk("rst_out",  out0, 8'h00);
        chk("rst_oeb",  oeb0, 8'hFF);
        chk("rst_lvl",  lvl0, 3'd0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_rdy",  rdy0, 1'b0);
        step(1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        step(2);

        // T1: 01..0A, FF, 00 back-to-back, each shown exactly 4 clocks.
        lg_prev = out0;
        lg_len  = 0;
        lg_on   = 1'b1;
        for (int i = 0; i < 12; i++) push0(t1_seq[i]);
        step(25);
        lg_on = 1'b0;
        chk("t1_runs", run_val.size(), 32'd12);
        for (int k = 1; k < 12; k++) begin
            if (k < run_val.size()) begin
                chk("t1_val", run_val[k], t1_seq[k-1]);
                chk("t1_len", run_len[k], 32'd4);
            end
        end
        sample();
        chk("t1_final_out",  out0, 8'h00);
        chk("t1_final_busy", busy0, 1'b0);
        chk("t1_saw_full",   saw_full, 1'b1);
        step(1);

        // T2: single byte into an idle FIFO appears one edge after handshake.
        push0(8'h5A);
        sample();
        chk("t2_out_e",  out0, 8'h00);
        chk("t2_busy_e", busy0, 1'b1);
        step(1);
        sample();
        chk("t2_out_e1", out0, 8'h5A);
        step(4);
        sample();
        chk("t2_busy_end", busy0, 1'b0);
        chk("t2_out_end",  out0, 8'h5A);
        step(3);

        // T3: continuous pushes fill the FIFO; no byte lost or duplicated.
        for (int i = 0; i < 5; i++) push0(8'h41 + 8'(i));
        sample();
        chk("t3_lvl_full", lvl0, 3'd4);
        chk("t3_rdy_full", rdy0, 1'b0);
        step(1);
        push0(8'h46);
        step(30);

        // T4: freeze after 2 clocks of a 4-clock hold, resume with 2 left.
        push0(8'h11);
        push0(8'h22);
        step(2);
        en0 = 1'b0;
        step(1);
        sample();
        chk("t4_oeb_off", oeb0, 8'hFF);
        chk("t4_out_frz", out0, 8'h11);
        chk("t4_rdy_off", rdy0, 1'b0);
        step(9);
        sample();
        chk("t4_out_frz2", out0, 8'h11);
        step(0);
        en0 = 1'b1;
        step(1);
        sample();
        chk("t4_oeb_on", oeb0, 8'h00);
        chk("t4_out_res", out0, 8'h11);
        step(1);
        sample();
        chk("t4_out_next", out0, 8'h22);
        step(8);

        // T5: reset mid-hold with 3 bytes queued discards them.
        for (int i = 0; i < 4; i++) push0(8'h71 + 8'(i));
        rst0 = 1'b1;
        step(1);
        sample();
        chk("t5_out",  out0, 8'h00);
        chk("t5_oeb",  oeb0, 8'hFF);
        chk("t5_lvl",  lvl0, 3'd0);
        chk("t5_rdy",  rdy0, 1'b0);
        chk("t5_busy", busy0, 1'b0);
        step(0);
        rst0 = 1'b0;
        step(20);
        sample();
        chk("t5_out_after", out0, 8'h00);
        chk("t5_lvl_after", lvl0, 3'd0);
        step(1);

        // T6: HOLD=1 streaming; pads change every clock, order intact.
        v1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d1 = 8'h31 + 8'(k);
            sample();
            chk("t6_rdy", rdy1, 1'b1);
            if (k >= 2) chk("t6_out", out1, 8'h31 + 8'(k - 2));
            @(posedge clk);
            #2;
        end
        v1 = 1'b0;
        sample();
        chk("t6_out_6", out1, 8'h37);
        step(1);
        sample();
        chk("t6_out_7", out1, 8'h38);
        step(3);
        sample();
        chk("t6_out_end",  out1, 8'h38);
        chk("t6_busy_end", busy1, 1'b0);

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
